bsram_arbiter: RTL and testbench

Arbiter and sequencer for the single-port program BSRAM, shared between the program loader (boot/UART write path) and the CPU instruction-fetch path. It accepts valid/ready requests from both, sequences one memory access at a time onto the BSRAM `ce`/`wre`/`ad`/`din` pins, and returns read data or a write acknowledgement to the granted requester. It sits between the loader, the CPU and the `Gowin_SP` instance, replacing the ad-hoc `boot_mode` address mux.

---
 rtl/bsram_arbiter.sv | 168 ++++++++++++++++
 tb/tb_bsram_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/bsram_arbiter.sv
// Arbiter/sequencer for the shared single-port program BSRAM: loader vs CPU fetch,
// one access at a time, with a bounded loader burst so the CPU is not starved.
module bsram_arbiter #(
    parameter int unsigned ADDR_W        = 11,
    parameter int unsigned DATA_W        = 16,
    parameter int unsigned READ_LATENCY  = 1,
    parameter int unsigned MAX_LDR_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ldr_lock,
    input  logic              ldr_valid,
    output logic              ldr_ready,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_rsp_valid,
    output logic [DATA_W-1:0] ldr_rdata,
    input  logic              cpu_valid,
    output logic              cpu_ready,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_rsp_valid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_ce,
    output logic              mem_wre,
    output logic [ADDR_W-1:0] mem_ad,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e            state_q, state_d;
    logic [3:0]        burst_q, burst_d;
    logic [1:0]        wait_cnt_q, wait_cnt_d;
    logic              port_cpu_q, port_cpu_d;
    logic              mem_ce_q, mem_ce_d;
    logic              mem_wre_q, mem_wre_d;
    logic [ADDR_W-1:0] mem_ad_q, mem_ad_d;
    logic [DATA_W-1:0] mem_din_q, mem_din_d;
    logic              ldr_rsp_valid_q, ldr_rsp_valid_d;
    logic [DATA_W-1:0] ldr_rdata_q, ldr_rdata_d;
    logic              cpu_rsp_valid_q, cpu_rsp_valid_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic              busy_q, busy_d;

    logic burst_full, ldr_grant, cpu_grant, idle, ldr_hs, cpu_hs;

    assign burst_full = (burst_q == 4'(MAX_LDR_BURST));
    assign idle       = (state_q == StIdle);

    // Lock locks out the CPU entirely; otherwise the loader wins ties until its burst is spent.
    assign ldr_grant = ldr_valid && (ldr_lock || !cpu_valid || !burst_full);
    assign cpu_grant = cpu_valid && !ldr_lock && (!ldr_valid || burst_full);

    assign ldr_ready = idle && !rst && ldr_grant;
    assign cpu_ready = idle && !rst && cpu_grant;
    assign ldr_hs    = ldr_valid && ldr_ready;
    assign cpu_hs    = cpu_valid && cpu_ready;

    always_comb begin
        state_d         = state_q;
        burst_d         = burst_q;
        wait_cnt_d      = wait_cnt_q;
        port_cpu_d      = port_cpu_q;
        mem_ce_d        = 1'b0;
        mem_wre_d       = 1'b0;
        mem_ad_d        = mem_ad_q;
        mem_din_d       = mem_din_q;
        ldr_rsp_valid_d = 1'b0;
        ldr_rdata_d     = ldr_rdata_q;
        cpu_rsp_valid_d = 1'b0;
        cpu_rdata_d     = cpu_rdata_q;

        if (ldr_lock) begin
            burst_d = 4'd0;
        end else if (ldr_hs) begin
            if (!cpu_valid)       burst_d = 4'd0;
            else if (!burst_full) burst_d = burst_q + 4'd1;
        end else if (cpu_hs) begin
            burst_d = 4'd0;
        end

        case (state_q)
            StIdle: begin
                if (ldr_hs || cpu_hs) begin
                    state_d    = StIssue;
                    port_cpu_d = cpu_hs;
                    mem_ce_d   = 1'b1;
                    mem_wre_d  = ldr_hs && ldr_we;
                    mem_ad_d   = cpu_hs ? cpu_addr : ldr_addr;
                    mem_din_d  = cpu_hs ? mem_din_q : ldr_wdata;
                end
            end
            StIssue: begin
                // mem_wre_q still carries the write flag of the access being issued
                if (mem_wre_q) begin
                    state_d         = StIdle;
                    ldr_rsp_valid_d = 1'b1;
                end else begin
                    state_d    = StWait;
                    wait_cnt_d = 2'd0;
                end
            end
            StWait: begin
                if (wait_cnt_q == 2'(READ_LATENCY - 1)) begin
                    state_d = StIdle;
                    if (port_cpu_q) begin
                        cpu_rdata_d     = mem_dout;
                        cpu_rsp_valid_d = 1'b1;
                    end else begin
                        ldr_rdata_d     = mem_dout;
                        ldr_rsp_valid_d = 1'b1;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= StIdle;
            burst_q         <= 4'd0;
            wait_cnt_q      <= 2'd0;
            port_cpu_q      <= 1'b0;
            mem_ce_q        <= 1'b0;
            mem_wre_q       <= 1'b0;
            mem_ad_q        <= '0;
            mem_din_q       <= '0;
            ldr_rsp_valid_q <= 1'b0;
            ldr_rdata_q     <= '0;
            cpu_rsp_valid_q <= 1'b0;
            cpu_rdata_q     <= '0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            burst_q         <= burst_d;
            wait_cnt_q      <= wait_cnt_d;
            port_cpu_q      <= port_cpu_d;
            mem_ce_q        <= mem_ce_d;
            mem_wre_q       <= mem_wre_d;
            mem_ad_q        <= mem_ad_d;
            mem_din_q       <= mem_din_d;
            ldr_rsp_valid_q <= ldr_rsp_valid_d;
            ldr_rdata_q     <= ldr_rdata_d;
            cpu_rsp_valid_q <= cpu_rsp_valid_d;
            cpu_rdata_q     <= cpu_rdata_d;
            busy_q          <= busy_d;
        end
    end

    assign mem_ce        = mem_ce_q;
    assign mem_wre       = mem_wre_q;
    assign mem_ad        = mem_ad_q;
    assign mem_din       = mem_din_q;
    assign ldr_rsp_valid = ldr_rsp_valid_q;
    assign ldr_rdata     = ldr_rdata_q;
    assign cpu_rsp_valid = cpu_rsp_valid_q;
    assign cpu_rdata     = cpu_rdata_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_bsram_arbiter.sv
// Directed bench for bsram_arbiter: default instance plus a READ_LATENCY=2 instance,
// each with its own behavioural BSRAM model.
module tb_bsram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ldr_lock, ldr_valid, ldr_we, cpu_valid;
    logic [10:0] ldr_addr, cpu_addr;
    logic [15:0] ldr_wdata;
    logic        ldr_ready, ldr_rsp_valid, cpu_ready, cpu_rsp_valid;
    logic [15:0] ldr_rdata, cpu_rdata;
    logic        mem_ce, mem_wre, busy;
    logic [10:0] mem_ad;
    logic [15:0] mem_din, mem_dout;

    logic        cpu_valid2;
    logic [10:0] cpu_addr2;
    logic        ldr_ready2, ldr_rsp_valid2, cpu_ready2, cpu_rsp_valid2;
    logic [15:0] ldr_rdata2, cpu_rdata2;
    logic        mem_ce2, mem_wre2, busy2;
    logic [10:0] mem_ad2;
    logic [15:0] mem_din2, mem_dout2;

    logic [15:0] mem  [0:2047];
    logic [15:0] mem2 [0:2047];
    logic [15:0] q1, q1b, q2b;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    bsram_arbiter dut (
        .clk(clk), .rst(rst), .ldr_lock(ldr_lock),
        .ldr_valid(ldr_valid), .ldr_ready(ldr_ready), .ldr_we(ldr_we),
        .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_rsp_valid(ldr_rsp_valid), .ldr_rdata(ldr_rdata),
        .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_addr(cpu_addr),
        .cpu_rsp_valid(cpu_rsp_valid), .cpu_rdata(cpu_rdata),
        .mem_ce(mem_ce), .mem_wre(mem_wre), .mem_ad(mem_ad), .mem_din(mem_din),
        .mem_dout(mem_dout), .busy(busy)
    );

    bsram_arbiter #(.READ_LATENCY(2)) dut2 (
        .clk(clk), .rst(rst), .ldr_lock(1'b0),
        .ldr_valid(1'b0), .ldr_ready(ldr_ready2), .ldr_we(1'b0),
        .ldr_addr(11'd0), .ldr_wdata(16'd0),
        .ldr_rsp_valid(ldr_rsp_valid2), .ldr_rdata(ldr_rdata2),
        .cpu_valid(cpu_valid2), .cpu_ready(cpu_ready2), .cpu_addr(cpu_addr2),
        .cpu_rsp_valid(cpu_rsp_valid2), .cpu_rdata(cpu_rdata2),
        .mem_ce(mem_ce2), .mem_wre(mem_wre2), .mem_ad(mem_ad2), .mem_din(mem_din2),
        .mem_dout(mem_dout2), .busy(busy2)
    );

    always @(posedge clk) begin
        if (mem_ce) begin
            if (mem_wre) mem[mem_ad] <= mem_din;
            else         q1 <= mem[mem_ad];
        end
        if (mem_ce2) begin
            if (mem_wre2) mem2[mem_ad2] <= mem_din2;
            else          q1b <= mem2[mem_ad2];
        end
        q2b <= q1b;
    end
    assign mem_dout  = q1;
    assign mem_dout2 = q2b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Full CPU read on the default instance, checking every cycle from N to N+4.
    task automatic cpu_read(input logic [10:0] addr, input logic [15:0] exp);
        go(); cpu_valid = 1'b1; cpu_addr = addr;
        mid(); chk("rd_ready", cpu_ready, 1);
        go(); cpu_valid = 1'b0;
        mid(); chk("rd_issue_ce", {mem_ce, mem_wre, busy}, 3'b101);
        chk("rd_issue_ad", mem_ad, addr);
        go(); mid(); chk("rd_wait", {mem_ce, cpu_rsp_valid, busy}, 3'b001);
        go(); mid(); chk("rd_rsp", cpu_rsp_valid, 1);
        chk("rd_data", cpu_rdata, exp);
        go(); mid(); chk("rd_rsp_pulse", cpu_rsp_valid, 0);
        chk("rd_data_hold", cpu_rdata, exp);
    endtask

    initial begin
        int g, cyc, cpu_seen;
        logic [9:0] order;
        mem[5]  = 16'h00A1;
        mem2[5] = 16'h00A1;
        rst = 1'b1; ldr_lock = 1'b0; ldr_we = 1'b0;
        ldr_valid = 1'b1; ldr_addr = 11'h7; ldr_wdata = 16'h0;
        cpu_valid = 1'b1; cpu_addr = 11'h5;
        cpu_valid2 = 1'b0; cpu_addr2 = 11'h0;

        // Reset with both ports requesting
        go(); go(); mid();
        chk("rst_ready", {ldr_ready, cpu_ready}, 2'b00);
        chk("rst_outs", {mem_ce, mem_wre, busy, ldr_rsp_valid, cpu_rsp_valid}, 5'b0);
        chk("rst_bus", {mem_ad, mem_din, ldr_rdata, cpu_rdata}, 59'd0);

        // Release: CPU read of 0x005 starts in the first IDLE cycle
        go(); rst = 1'b0; ldr_valid = 1'b0;
        mid(); chk("rel_cpu_ready", cpu_ready, 1);
        go(); cpu_valid = 1'b0;
        mid(); chk("rel_issue", {mem_ce, mem_wre, mem_ad}, {2'b10, 11'h005});
        go(); mid(); chk("rel_n2_rsp", cpu_rsp_valid, 0);
        go(); mid(); chk("rel_n3_rsp", {cpu_rsp_valid, cpu_rdata}, {1'b1, 16'h00A1});
        go(); mid(); chk("rel_n4_rsp", cpu_rsp_valid, 0);

        // Loader write 0xBEEF -> 0x123, then CPU read back
        go(); ldr_valid = 1'b1; ldr_we = 1'b1; ldr_addr = 11'h123; ldr_wdata = 16'hBEEF;
        mid(); chk("wr_ready", {ldr_ready, cpu_ready}, 2'b10);
        go(); ldr_valid = 1'b0;
        mid(); chk("wr_issue", {mem_ce, mem_wre, mem_ad, mem_din}, {2'b11, 11'h123, 16'hBEEF});
        go(); mid(); chk("wr_rsp", {mem_wre, ldr_rsp_valid, busy}, 3'b010);
        chk("wr_rdata_keep", ldr_rdata, 0);
        go(); mid(); chk("wr_rsp_pulse", ldr_rsp_valid, 0);
        cpu_read(11'h123, 16'hBEEF);

        // Fairness: streaming loader writes against a persistent CPU request
        g = 0; cyc = 0; order = '0;
        go(); ldr_valid = 1'b1; ldr_we = 1'b1; ldr_addr = 11'h300; ldr_wdata = 16'h1111;
        cpu_valid = 1'b1; cpu_addr = 11'h5;
        while (g < 10 && cyc < 200) begin
            mid();
            if (ldr_ready) g++;
            else if (cpu_ready) begin order[g] = 1'b1; g++; end
            cyc++;
            if (g < 10) go();
        end
        chk("fair_count", g, 10);
        chk("fair_order", {22'd0, order}, 32'h210);
        go(); ldr_valid = 1'b0; cpu_valid = 1'b0;
        repeat (4) go();

        // Lock: CPU never granted across 20 loader writes
        g = 0; cyc = 0; cpu_seen = 0;
        ldr_lock = 1'b1; ldr_valid = 1'b1; ldr_addr = 11'h301; ldr_wdata = 16'h2222;
        cpu_valid = 1'b1; cpu_addr = 11'h5;
        while (g < 20 && cyc < 200) begin
            mid();
            if (ldr_ready) g++;
            if (cpu_ready) cpu_seen++;
            cyc++;
            if (g < 20) go();
        end
        chk("lock_ldr_grants", g, 20);
        chk("lock_cpu_never", cpu_seen, 0);
        go(); ldr_lock = 1'b0; ldr_valid = 1'b0;
        mid(); chk("unlock_issue", cpu_ready, 0);
        go(); mid(); chk("unlock_grant", cpu_ready, 1);
        go(); cpu_valid = 1'b0;
        repeat (4) go();

        // Reset during WAIT drops the read
        cpu_valid = 1'b1; cpu_addr = 11'h5;
        mid(); chk("mr_ready", cpu_ready, 1);
        go(); cpu_valid = 1'b0;
        go(); rst = 1'b1;
        mid(); chk("mr_outs", {cpu_rsp_valid, mem_ce, busy, mem_ad, cpu_rdata}, 30'd0);
        go(); rst = 1'b0;
        mid(); chk("mr_no_rsp", cpu_rsp_valid, 0);
        go(); mid(); chk("mr_no_rsp2", cpu_rsp_valid, 0);
        cpu_read(11'h005, 16'h00A1);

        // READ_LATENCY=2 instance: response at N+4
        go(); cpu_valid2 = 1'b1; cpu_addr2 = 11'h5;
        mid(); chk("l2_ready", cpu_ready2, 1);
        go(); cpu_valid2 = 1'b0;
        mid(); chk("l2_issue", {mem_ce2, mem_ad2}, {1'b1, 11'h005});
        go(); mid(); chk("l2_n2", cpu_rsp_valid2, 0);
        go(); mid(); chk("l2_n3", {cpu_rsp_valid2, busy2}, 2'b01);
        go(); mid(); chk("l2_n4", {cpu_rsp_valid2, cpu_rdata2}, {1'b1, 16'h00A1});
        go(); mid(); chk("l2_n5", cpu_rsp_valid2, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
